// File: rtl/sha_block_sequencer_pkg.sv
// Shared constants for the SHA-384/512 message sequencer: initial hash values,
// mode encodings, controller state type and the digest masking helper.
package sha_pkg;

  localparam logic MODE_512 = 1'b0;
  localparam logic MODE_384 = 1'b1;

  localparam logic [511:0] SHA512_IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [511:0] SHA384_IV = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CORE,
    ST_START,
    ST_BUSY,
    ST_DIGEST,
    ST_DRAIN
  } seq_state_e;

  function automatic logic [511:0] iv_for_mode(input logic mode);
    return (mode == MODE_384) ? SHA384_IV : SHA512_IV;
  endfunction

  // SHA-384 publishes only the first six chaining words.
  function automatic logic [511:0] digest_mask(input logic mode, input logic [511:0] h);
    return (mode == MODE_384) ? {h[511:128], 128'h0} : h;
  endfunction

endpackage

// File: rtl/sha_block_sequencer.sv
// Message-level controller for the SHA-384/512 compression core: feeds padded
// blocks, chains each compression result into the next, and presents the digest.
module sha_block_sequencer
  import sha_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [1023:0]    blk_data,
  input  logic             blk_last,
  input  logic             blk_mode,
  input  logic             abort,
  output logic [1023:0]    core_M,
  output logic [511:0]     core_H,
  output logic             core_mode,
  output logic             core_run,
  input  logic             core_ready,
  input  logic             core_done,
  input  logic [511:0]     core_hash,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [511:0]     dig_data,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count
);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic             r_acc;
  logic             w_acc_nxt;
  logic             r_live;
  logic [1023:0]    r_m;
  logic [511:0]     r_h;
  logic             r_mode;
  logic             r_last;
  logic [CNT_W-1:0] r_count;

  logic             w_blk_ready;
  logic             w_load_first;
  logic             w_load_next;
  logic             w_take_hash;

  // r_live keeps blk_ready low while rst_n is asserted, so every output reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process evaluation order.
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a variable
    // unassigned and infers a latch.
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    case (r_state)
      ST_IDLE: begin
        if (!abort && blk_valid && w_blk_ready) w_state_nxt = ST_WAIT_CORE;
      end
      ST_WAIT_CORE: begin
        if (abort)           w_state_nxt = ST_IDLE;
        else if (core_ready) w_state_nxt = ST_START;
      end
      ST_START: begin
        w_state_nxt = abort ? ST_DRAIN : ST_BUSY;
      end
      ST_BUSY: begin
        if (r_acc) begin
          if (abort)                       w_state_nxt = ST_IDLE;
          else if (blk_valid && w_blk_ready) w_state_nxt = ST_WAIT_CORE;
        end else begin
          if (abort)          w_state_nxt = ST_DRAIN;
          else if (core_done) begin
            if (r_last) w_state_nxt = ST_DIGEST;
            else        w_acc_nxt   = 1'b1;
          end
        end
      end
      ST_DIGEST: begin
        if (abort || dig_ready) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (core_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // The accept sub-phase only exists inside BUSY.
    if (w_state_nxt != ST_BUSY) w_acc_nxt = 1'b0;
  end

  always_comb begin
    w_blk_ready  = 1'b0;
    w_load_first = 1'b0;
    w_load_next  = 1'b0;
    w_take_hash  = 1'b0;
    core_run     = 1'b0;
    dig_valid    = 1'b0;
    dig_data     = '0;
    busy         = (r_state != ST_IDLE);

    // abort outranks a block handshake, so it also withdraws blk_ready.
    w_blk_ready = r_live && !abort &&
                  ((r_state == ST_IDLE) || ((r_state == ST_BUSY) && r_acc));
    w_load_first = (r_state == ST_IDLE) && blk_valid && w_blk_ready;
    w_load_next  = (r_state == ST_BUSY) && r_acc && blk_valid && w_blk_ready;
    w_take_hash  = (r_state == ST_BUSY) && !r_acc && core_done && !abort;

    core_run = (r_state == ST_START);
    if (r_state == ST_DIGEST) begin
      dig_valid = 1'b1;
      dig_data  = digest_mask(r_mode, r_h);
    end
  end

  // NOTE: the wide datapath registers are reset explicitly because they drive
  // ports that must read 0 out of reset; they are flops, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m     <= '0;
      r_h     <= '0;
      r_mode  <= MODE_512;
      r_last  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_load_first) begin
        r_m     <= blk_data;
        r_last  <= blk_last;
        r_mode  <= blk_mode;
        r_h     <= iv_for_mode(blk_mode);
        r_count <= '0;
      end
      if (w_load_next) begin
        r_m    <= blk_data;
        r_last <= blk_last;
      end
      if (w_take_hash) begin
        r_h <= core_hash;
        if (r_count != '1) r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign blk_ready = w_blk_ready;
  assign core_M    = r_m;
  assign core_H    = r_h;
  assign core_mode = r_mode;
  assign blk_count = r_count;

endmodule
